mem_arbiter: RTL and testbench

Shares the single unified instruction/data memory between two requesters: the multi-cycle CPU controller (port C) and a program-loader/DMA engine (port D). Arbitrates between them, sequences each access over a fixed memory latency, steers read data back to the owner and signals completion. Sits between the CPU datapath memory interface and the memory macro.

---
 rtl/mem_arb_pkg.sv | 21 ++
 rtl/arb_rr2.sv | 30 +++
 rtl/mem_arbiter.sv | 168 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types for the unified-memory arbiter.
// State and owner encodings plus the latency counter width helper.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_e;

  // Counter holds MEM_LAT-1 down to 0; never narrower than one bit.
  function automatic int cnt_w(input int lat);
    return (lat < 2) ? 1 : $clog2(lat);
  endfunction

endpackage

// File: rtl/arb_rr2.sv
// arb_rr2: two-way arbiter, round-robin on a last-owner pointer,
// with a CPU fixed-priority override (prio_c). Purely combinational.
// Ports: req_c/req_d requests, last_owner pointer -> gnt_vld, gnt_own.
module arb_rr2
  import mem_arb_pkg::*;
(
  input  logic   req_c,
  input  logic   req_d,
  input  logic   prio_c,
  input  owner_e last_owner,
  output logic   gnt_vld,
  output owner_e gnt_own
);

  always_comb begin
    gnt_vld = req_c | req_d;
    gnt_own = OWN_CPU;
    unique case (1'b1)
      (req_c & ~req_d): gnt_own = OWN_CPU;
      (~req_c & req_d): gnt_own = OWN_DMA;
      (req_c & req_d): begin
        // Tie: CPU wins under priority, else whoever went last loses.
        if (prio_c || last_owner == OWN_DMA) gnt_own = OWN_CPU;
        else                                 gnt_own = OWN_DMA;
      end
      default: gnt_own = OWN_CPU;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory between the CPU (C) and DMA (D) ports.
// Ports: cpu_*/dma_* requester sides, mem_* memory macro side, clk, rst (async, low).
// Each access: IDLE sample -> MEM_LAT ACCESS cycles -> one RESP cycle (done pulse).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 8,
  parameter int MEM_LAT  = 2,
  parameter int CPU_PRIO = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_done,
  output logic              cpu_wait,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_done,
  output logic              dma_gnt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_re,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CW = cnt_w(MEM_LAT);
  localparam logic [CW-1:0] CNT_INIT = CW'(MEM_LAT - 1);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  owner_e            last_q, last_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              re_q, re_d;
  logic              wstb_q, wstb_d;
  logic              gnt_q, gnt_d;
  logic              cdone_q, cdone_d;
  logic              ddone_q, ddone_d;
  logic [DATA_W-1:0] crd_q, crd_d;
  logic [DATA_W-1:0] drd_q, drd_d;

  logic   gnt_vld;
  owner_e gnt_own;

  arb_rr2 u_arb (
    .req_c      (cpu_req),
    .req_d      (dma_req),
    .prio_c     (CPU_PRIO != 0),
    .last_owner (last_q),
    .gnt_vld    (gnt_vld),
    .gnt_own    (gnt_own)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    re_d    = 1'b0;
    wstb_d  = 1'b0;
    gnt_d   = gnt_q;
    cdone_d = 1'b0;
    ddone_d = 1'b0;
    crd_d   = crd_q;
    drd_d   = drd_q;
    unique case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          owner_d = gnt_own;
          if (gnt_own == OWN_CPU) begin
            addr_d  = cpu_addr;
            wdata_d = cpu_wdata;
            we_d    = cpu_we;
          end else begin
            addr_d  = dma_addr;
            wdata_d = dma_wdata;
            we_d    = dma_we;
          end
          cnt_d   = CNT_INIT;
          re_d    = ~we_d;
          wstb_d  = we_d;
          gnt_d   = (gnt_own == OWN_DMA);
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          if (!we_q) begin
            if (owner_q == OWN_CPU) crd_d = mem_rdata;
            else                    drd_d = mem_rdata;
          end
          cdone_d = (owner_q == OWN_CPU);
          ddone_d = (owner_q == OWN_DMA);
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
          re_d  = ~we_q;
        end
      end
      RESP: begin
        last_d  = owner_q;
        gnt_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      owner_q <= OWN_CPU;
      last_q  <= OWN_DMA;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
      wstb_q  <= 1'b0;
      gnt_q   <= 1'b0;
      cdone_q <= 1'b0;
      ddone_q <= 1'b0;
      crd_q   <= '0;
      drd_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      re_q    <= re_d;
      wstb_q  <= wstb_d;
      gnt_q   <= gnt_d;
      cdone_q <= cdone_d;
      ddone_q <= ddone_d;
      crd_q   <= crd_d;
      drd_q   <= drd_d;
    end
  end

  assign cpu_rdata = crd_q;
  assign cpu_done  = cdone_q;
  assign cpu_wait  = cpu_req & ~cdone_q;
  assign dma_rdata = drd_q;
  assign dma_done  = ddone_q;
  assign dma_gnt   = gnt_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_re    = re_q;
  assign mem_we    = wstb_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: three arbiter instances (RR lat2, CPU-prio lat2, RR lat1)
// checked every cycle against a transaction-level timing model.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]       cpu_req = '0, cpu_we = '0, dma_req = '0, dma_we = '0;
  logic [2:0][4:0]  cpu_addr = '0, dma_addr = '0;
  logic [2:0][7:0]  cpu_wdata = '0, dma_wdata = '0;
  logic [2:0][7:0]  cpu_rdata, dma_rdata, mem_wdata, mem_rdata;
  logic [2:0][4:0]  mem_addr;
  logic [2:0]       cpu_done, cpu_wait, dma_done, dma_gnt, mem_re, mem_we;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  function automatic logic [7:0] init_val(input int g, input int a);
    return 8'(a * 29 + 18 + g * 7);
  endfunction

  function automatic int lat_of(input int i);
    return (i == 2) ? 1 : 2;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic [7:0] emem [32];
    mem_arbiter #(
      .ADDR_W(5), .DATA_W(8),
      .MEM_LAT(g == 2 ? 1 : 2),
      .CPU_PRIO(g == 1 ? 1 : 0)
    ) u_dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req[g]), .cpu_we(cpu_we[g]),
      .cpu_addr(cpu_addr[g]), .cpu_wdata(cpu_wdata[g]),
      .cpu_rdata(cpu_rdata[g]), .cpu_done(cpu_done[g]),
      .cpu_wait(cpu_wait[g]),
      .dma_req(dma_req[g]), .dma_we(dma_we[g]),
      .dma_addr(dma_addr[g]), .dma_wdata(dma_wdata[g]),
      .dma_rdata(dma_rdata[g]), .dma_done(dma_done[g]),
      .dma_gnt(dma_gnt[g]),
      .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]),
      .mem_re(mem_re[g]), .mem_we(mem_we[g]),
      .mem_rdata(mem_rdata[g])
    );
    assign mem_rdata[g] = mem_re[g] ? emem[mem_addr[g]] : 8'hEE;
    always @(posedge clk) begin
      if (!rst) begin
        for (int a = 0; a < 32; a++) emem[a] <= init_val(g, a);
      end else if (mem_we[g]) begin
        emem[mem_addr[g]] <= mem_wdata[g];
      end
    end
  end

  // Transaction-level model: one pending access per instance with its
  // sample cycle; everything else follows from arithmetic on cycle numbers.
  bit         m_act [3];
  bit         m_dma [3];
  bit         m_we  [3];
  bit         m_last_dma [3];
  int         m_start [3];
  int         m_next [3];
  logic [4:0] m_addr [3];
  logic [7:0] m_wd [3], m_rd [3], e_crd [3], e_drd [3];
  logic [7:0] mmem [3][32];

  task automatic chk(input string nm, input int i,
                     input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s dut%0d cyc=%0d got=0x%0h expected=0x%0h",
               nm, i, cyc, got, exp);
    end
  endtask

  task automatic model_check();
    for (int i = 0; i < 3; i++) begin
      int lat;
      bit acc, resp, e_re, e_we, e_cd, e_dd, e_gnt, cr, dr, wd;
      lat = lat_of(i);
      if (!rst) begin
        m_act[i] = 0;
        m_last_dma[i] = 1;
        e_crd[i] = '0;
        e_drd[i] = '0;
        m_next[i] = cyc + 1;
        for (int a = 0; a < 32; a++) mmem[i][a] = init_val(i, a);
      end
      acc  = m_act[i] && cyc > m_start[i] && cyc <= m_start[i] + lat;
      resp = m_act[i] && cyc == m_start[i] + lat + 1;
      if (resp && !m_we[i]) begin
        if (m_dma[i]) e_drd[i] = m_rd[i];
        else          e_crd[i] = m_rd[i];
      end
      e_re  = acc && !m_we[i];
      e_we  = acc && m_we[i] && cyc == m_start[i] + 1;
      e_cd  = resp && !m_dma[i];
      e_dd  = resp && m_dma[i];
      e_gnt = m_dma[i] && (acc || resp);
      chk("cpu_done", i, 32'(cpu_done[i]), 32'(e_cd));
      chk("dma_done", i, 32'(dma_done[i]), 32'(e_dd));
      chk("cpu_wait", i, 32'(cpu_wait[i]), 32'(cpu_req[i] & ~e_cd));
      chk("dma_gnt", i, 32'(dma_gnt[i]), 32'(e_gnt));
      chk("mem_re", i, 32'(mem_re[i]), 32'(e_re));
      chk("mem_we", i, 32'(mem_we[i]), 32'(e_we));
      chk("cpu_rdata", i, 32'(cpu_rdata[i]), 32'(e_crd[i]));
      chk("dma_rdata", i, 32'(dma_rdata[i]), 32'(e_drd[i]));
      if (e_re || e_we) chk("mem_addr", i, 32'(mem_addr[i]), 32'(m_addr[i]));
      if (e_we) chk("mem_wdata", i, 32'(mem_wdata[i]), 32'(m_wd[i]));
      if (resp) m_act[i] = 0;
      if (rst && cyc == m_next[i]) begin
        cr = cpu_req[i];
        dr = dma_req[i];
        if (cr || dr) begin
          wd = dr && (!cr || (i != 1 && !m_last_dma[i]));
          m_act[i]   = 1;
          m_dma[i]   = wd;
          m_start[i] = cyc;
          m_we[i]    = wd ? dma_we[i] : cpu_we[i];
          m_addr[i]  = wd ? dma_addr[i] : cpu_addr[i];
          m_wd[i]    = wd ? dma_wdata[i] : cpu_wdata[i];
          if (m_we[i]) mmem[i][m_addr[i]] = m_wd[i];
          else         m_rd[i] = mmem[i][m_addr[i]];
          m_last_dma[i] = wd;
          m_next[i] = cyc + lat + 2;
        end else begin
          m_next[i] = cyc + 1;
        end
      end
    end
    cyc++;
  endtask

  task automatic sample();
    @(negedge clk);
    model_check();
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc1();
    sample();
    advance();
  endtask

  task automatic wait_done(input int i, input bit dma, input int max,
                           output int n);
    bit seen;
    seen = 0;
    n = -1;
    for (int k = 0; k < max && !seen; k++) begin
      sample();
      if (dma ? dma_done[i] : cpu_done[i]) begin
        seen = 1;
        n = k;
      end
      advance();
    end
    if (seen) begin
      if (dma) dma_req[i] = 1'b0;
      else     cpu_req[i] = 1'b0;
    end
  endtask

  initial begin
    int n, cnt, first, consec;
    bit prev;
    bit cd [3];
    bit dd [3];

    // Reset state
    advance();
    cyc1();
    sample();
    chk("rst_cpu_done", 0, 32'(cpu_done[0]), 0);
    chk("rst_mem_re", 0, 32'(mem_re[0]), 0);
    chk("rst_dma_gnt", 0, 32'(dma_gnt[0]), 0);
    chk("rst_cpu_rdata", 0, 32'(cpu_rdata[0]), 0);
    advance();
    rst = 1'b1;

    // CPU read of addr 5 (word 0xA3)
    cpu_req[0] = 1; cpu_we[0] = 0; cpu_addr[0] = 5;
    sample();
    chk("rd_c0_wait", 0, 32'(cpu_wait[0]), 1);
    chk("rd_c0_re", 0, 32'(mem_re[0]), 0);
    advance();
    sample();
    chk("rd_c1_re", 0, 32'(mem_re[0]), 1);
    chk("rd_c1_addr", 0, 32'(mem_addr[0]), 5);
    advance();
    sample();
    chk("rd_c2_re", 0, 32'(mem_re[0]), 1);
    chk("rd_c2_wait", 0, 32'(cpu_wait[0]), 1);
    advance();
    sample();
    chk("rd_c3_done", 0, 32'(cpu_done[0]), 1);
    chk("rd_c3_rdata", 0, 32'(cpu_rdata[0]), 32'h A3);
    chk("rd_c3_wait", 0, 32'(cpu_wait[0]), 0);
    advance();
    cpu_req[0] = 0;
    sample();
    chk("rd_c4_done", 0, 32'(cpu_done[0]), 0);
    advance();

    // Tie after reset, round-robin
    rst = 1'b0;
    cyc1();
    rst = 1'b1;
    cpu_req[0] = 1; cpu_addr[0] = 3;
    dma_req[0] = 1; dma_we[0] = 0; dma_addr[0] = 7;
    wait_done(0, 0, 8, n);
    chk("tie_cpu_first", 0, 32'(n), 3);
    wait_done(0, 1, 8, n);
    chk("tie_dma_second", 0, 32'(n), 3);
    chk("tie_dma_rdata", 0, 32'(dma_rdata[0]), 32'h DD);
    cpu_req[0] = 1; dma_req[0] = 1;
    wait_done(0, 0, 8, n);
    chk("tie2_cpu_first", 0, 32'(n), 3);
    wait_done(0, 1, 8, n);
    chk("tie2_dma_second", 0, 32'(n), 3);

    // CPU priority: DMA starved while cpu_req held
    cpu_req[1] = 1; cpu_addr[1] = 1;
    dma_req[1] = 1; dma_addr[1] = 2;
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      sample();
      if (dma_gnt[1]) cnt++;
      advance();
    end
    chk("prio_starve", 1, 32'(cnt), 0);
    wait_done(1, 0, 8, n);
    chk("prio_cpu_done_seen", 1, 32'(n >= 0), 1);
    wait_done(1, 1, 8, n);
    chk("prio_dma_next", 1, 32'(n), 3);

    // DMA write 0x3C to addr 31
    dma_req[0] = 1; dma_we[0] = 1; dma_addr[0] = 31; dma_wdata[0] = 8'h3C;
    sample();
    chk("wr_c0_we", 0, 32'(mem_we[0]), 0);
    advance();
    sample();
    chk("wr_c1_we", 0, 32'(mem_we[0]), 1);
    chk("wr_c1_addr", 0, 32'(mem_addr[0]), 31);
    chk("wr_c1_data", 0, 32'(mem_wdata[0]), 32'h 3C);
    advance();
    sample();
    chk("wr_c2_we", 0, 32'(mem_we[0]), 0);
    advance();
    sample();
    chk("wr_c3_done", 0, 32'(dma_done[0]), 1);
    chk("wr_rdata_keep", 0, 32'(dma_rdata[0]), 32'h DD);
    advance();
    dma_req[0] = 0;
    cpu_req[0] = 1; cpu_we[0] = 0; cpu_addr[0] = 31;
    wait_done(0, 0, 8, n);
    chk("wr_readback_lat", 0, 32'(n), 3);
    chk("wr_readback", 0, 32'(cpu_rdata[0]), 32'h 3C);

    // Reset during second ACCESS cycle of a CPU read
    cpu_req[0] = 1; cpu_addr[0] = 9;
    cyc1();
    cyc1();
    rst = 1'b0;
    cnt = 0;
    sample();
    chk("rstmid_re", 0, 32'(mem_re[0]), 0);
    if (cpu_done[0]) cnt++;
    advance();
    sample();
    if (cpu_done[0]) cnt++;
    advance();
    chk("rstmid_no_done", 0, 32'(cnt), 0);
    rst = 1'b1;
    dma_req[0] = 1; dma_we[0] = 0; dma_addr[0] = 4;
    wait_done(0, 0, 8, n);
    chk("rstmid_tie_cpu", 0, 32'(n), 3);
    wait_done(0, 1, 8, n);
    chk("rstmid_dma_next", 0, 32'(n), 3);

    // MEM_LAT=1 back-to-back CPU reads
    cpu_req[2] = 1; cpu_we[2] = 0; cpu_addr[2] = 6;
    cnt = 0; first = -1; consec = 0; prev = 0;
    for (int k = 0; k < 12; k++) begin
      sample();
      if (cpu_done[2]) begin
        cnt++;
        if (first < 0) first = k;
        if (prev) consec++;
      end
      prev = cpu_done[2];
      advance();
    end
    cpu_req[2] = 0;
    chk("lat1_ndone", 2, 32'(cnt), 4);
    chk("lat1_first", 2, 32'(first), 2);
    chk("lat1_consec", 2, 32'(consec), 0);
    chk("lat1_rdata", 2, 32'(cpu_rdata[2]), 32'h CE);
    cyc1();

    // Randomized traffic on all instances
    for (int t = 0; t < 2500; t++) begin
      sample();
      for (int i = 0; i < 3; i++) begin
        cd[i] = cpu_done[i];
        dd[i] = dma_done[i];
      end
      advance();
      for (int i = 0; i < 3; i++) begin
        if (cpu_req[i] && cd[i]) cpu_req[i] = 0;
        else if (!cpu_req[i] && $urandom_range(0, 2) == 0) begin
          cpu_req[i] = 1;
          cpu_we[i] = 1'($urandom_range(0, 1));
          cpu_addr[i] = 5'($urandom);
          cpu_wdata[i] = 8'($urandom);
        end else if ($urandom_range(0, 7) == 0) begin
          cpu_we[i] = 1'($urandom_range(0, 1));
          cpu_addr[i] = 5'($urandom);
          cpu_wdata[i] = 8'($urandom);
        end
        if (dma_req[i] && dd[i]) dma_req[i] = 0;
        else if (!dma_req[i] && $urandom_range(0, 2) == 0) begin
          dma_req[i] = 1;
          dma_we[i] = 1'($urandom_range(0, 1));
          dma_addr[i] = 5'($urandom);
          dma_wdata[i] = 8'($urandom);
        end else if ($urandom_range(0, 7) == 0) begin
          dma_we[i] = 1'($urandom_range(0, 1));
          dma_addr[i] = 5'($urandom);
          dma_wdata[i] = 8'($urandom);
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
